// File: rtl/dac_spi_multi_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dac_spi_multi_if : sample request/ack handshake and shared DAC pin bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface dac_spi_multi_if #(
   parameter int N_CHANNELS = 2,
   parameter int DATA_WIDTH = 16
);
   logic [N_CHANNELS*DATA_WIDTH-1:0] dac_data;
   logic [N_CHANNELS-1:0]            dac_rq;
   logic [N_CHANNELS-1:0]            dac_ack;
   logic                             busy;
   logic                             sdata;
   logic                             bclk;
   logic [N_CHANNELS-1:0]            nsync;

   modport master (
      input  dac_data, dac_rq,
      output dac_ack, busy, sdata, bclk, nsync
   );

   modport slave (
      output dac_data, dac_rq,
      input  dac_ack, busy, sdata, bclk, nsync
   );
endinterface
`default_nettype wire

// File: rtl/dac_spi_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dac_spi_multi : round-robin multi-channel SPI master for AD5061-class DACs
// Revision 1.0
// ---------------------------------------------------------------------------
module dac_spi_multi #(
   parameter int                      CLKS_PER_BCLK = 4,
   parameter int                      DATA_WIDTH    = 16,
   parameter int                      FRAME_LENGTH  = 24,
   parameter logic [FRAME_LENGTH-1:0] PREFIX        = '0,
   parameter int                      N_CHANNELS    = 2,
   parameter bit                      CPOL          = 1'b1,
   parameter int                      MIN_GAP_CLKS  = 4
) (
   input wire logic        clock_in,
   input wire logic        reset,
   dac_spi_multi_if.master bus
);
   localparam int H       = CLKS_PER_BCLK / 2;
   localparam int PW      = FRAME_LENGTH - DATA_WIDTH;
   localparam int CNT_MAX = (H > MIN_GAP_CLKS) ? H : MIN_GAP_CLKS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BIT_W   = $clog2(FRAME_LENGTH + 1);
   localparam int PTR_W   = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_SHIFT = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [BIT_W-1:0]        bit_q, bit_d;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic [N_CHANNELS-1:0]   rq_q, rq_d;
   logic [FRAME_LENGTH-1:0] frame_q, frame_d;
   logic [N_CHANNELS-1:0]   ack_q, ack_d;
   logic [N_CHANNELS-1:0]   nsync_q, nsync_d;
   logic                    busy_q, busy_d;
   logic                    bclk_q, bclk_d;
   logic                    sdata_q, sdata_d;

   logic                    grant_vld;
   logic [PTR_W-1:0]        grant_ch;
   logic [PTR_W-1:0]        next_ptr;
   logic [N_CHANNELS-1:0]   grant_oh;
   logic [DATA_WIDTH-1:0]   sample;
   logic [FRAME_LENGTH-1:0] load_frame;
   logic [FRAME_LENGTH-1:0] shifted;

   // First pass covers channels at/after the pointer, second pass wraps to the lowest.
   always_comb begin
      grant_vld = 1'b0;
      grant_ch  = '0;
      grant_oh  = '0;
      sample    = '0;
      for (int c = 0; c < N_CHANNELS; c++) begin
         if (!grant_vld && rq_q[c] && (PTR_W'(c) >= ptr_q)) begin
            grant_vld   = 1'b1;
            grant_ch    = PTR_W'(c);
            grant_oh[c] = 1'b1;
         end
      end
      for (int c = 0; c < N_CHANNELS; c++) begin
         if (!grant_vld && rq_q[c]) begin
            grant_vld   = 1'b1;
            grant_ch    = PTR_W'(c);
            grant_oh[c] = 1'b1;
         end
      end
      for (int c = 0; c < N_CHANNELS; c++) begin
         if (grant_oh[c]) begin
            sample = bus.dac_data[c*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign next_ptr = (grant_ch == PTR_W'(N_CHANNELS - 1)) ? '0 : grant_ch + 1'b1;
   assign shifted  = frame_q << 1;

   generate
      if (PW > 0) begin : g_prefix
         assign load_frame = {PREFIX[PW-1:0], sample};
      end else begin : g_no_prefix
         assign load_frame = sample;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      ptr_d   = ptr_q;
      rq_d    = bus.dac_rq;
      frame_d = frame_q;
      ack_d   = '0;
      nsync_d = nsync_q;
      busy_d  = busy_q;
      bclk_d  = bclk_q;
      sdata_d = sdata_q;
      case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               state_d = S_SETUP;
               cnt_d   = '0;
               frame_d = load_frame;
               ack_d   = grant_oh;
               nsync_d = ~grant_oh;
               sdata_d = load_frame[FRAME_LENGTH-1];
               busy_d  = 1'b1;
               ptr_d   = next_ptr;
            end
         end
         S_SETUP: begin
            if (cnt_q == CNT_W'(H - 1)) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
               bit_d   = '0;
               bclk_d  = ~CPOL;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (cnt_q == CNT_W'(H - 1)) begin
               cnt_d = '0;
               if (bclk_q == CPOL) begin
                  bclk_d = ~CPOL;
               end else begin
                  // Trailing edge: the DAC has sampled, move on to the next bit.
                  bclk_d = CPOL;
                  if (bit_q == BIT_W'(FRAME_LENGTH - 1)) begin
                     nsync_d = '1;
                     sdata_d = 1'b0;
                     state_d = S_GAP;
                  end else begin
                     frame_d = shifted;
                     sdata_d = shifted[FRAME_LENGTH-1];
                     bit_d   = bit_q + 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == CNT_W'(MIN_GAP_CLKS - 1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         ptr_q   <= '0;
         rq_q    <= '0;
         frame_q <= '0;
         ack_q   <= '0;
         nsync_q <= '1;
         busy_q  <= 1'b0;
         bclk_q  <= CPOL;
         sdata_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         ptr_q   <= ptr_d;
         rq_q    <= rq_d;
         frame_q <= frame_d;
         ack_q   <= ack_d;
         nsync_q <= nsync_d;
         busy_q  <= busy_d;
         bclk_q  <= bclk_d;
         sdata_q <= sdata_d;
      end
   end

   assign bus.dac_ack = ack_q;
   assign bus.nsync   = nsync_q;
   assign bus.busy    = busy_q;
   assign bus.bclk    = bclk_q;
   assign bus.sdata   = sdata_q;
endmodule
`default_nettype wire

// File: tb/tb_dac_spi_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dac_spi_multi : directed bench, default build plus a narrow CPOL=0 build
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_dac_spi_multi;
   typedef struct {
      int          ch;
      logic [31:0] bits;
      int          leads;
      int          low;
      int          start;
   } frame_t;

   logic   clk;
   logic   reset_n;
   int     n_vec;
   int     n_err;
   int     cyc;
   int     overlap;
   int     ack_cnt [2];
   frame_t cur_a;
   frame_t cur_b;
   frame_t fa[$];
   frame_t fb[$];
   frame_t f0, f1, f2, f3;

   dac_spi_multi_if #(.N_CHANNELS(2), .DATA_WIDTH(16)) bus_a ();
   dac_spi_multi_if #(.N_CHANNELS(1), .DATA_WIDTH(16)) bus_b ();

   dac_spi_multi dut_a (
      .clock_in (clk),
      .reset    (reset_n),
      .bus      (bus_a.master)
   );

   dac_spi_multi #(
      .CLKS_PER_BCLK (2),
      .DATA_WIDTH    (16),
      .FRAME_LENGTH  (16),
      .N_CHANNELS    (1),
      .CPOL          (1'b0)
   ) dut_b (
      .clock_in (clk),
      .reset    (reset_n),
      .bus      (bus_b.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic frame_t fa_at(input int i);
      frame_t f;
      f = '{-1, 32'h0, -1, -1, -1};
      if (i < fa.size()) f = fa[i];
      return f;
   endfunction

   // Frame recorder for the default build: bits are captured at CPOL=1 leading (falling) edges.
   initial begin
      logic [1:0] pn;
      logic       pb;
      pn = 2'b11; pb = 1'b1; cyc = 0; overlap = 0;
      ack_cnt[0] = 0; ack_cnt[1] = 0;
      cur_a = '{0, 32'h0, 0, 0, 0};
      forever begin
         @(negedge clk);
         cyc++;
         for (int c = 0; c < 2; c++) begin
            if (pn[c] && !bus_a.nsync[c]) cur_a = '{c, 32'h0, 0, 0, cyc};
            if (bus_a.dac_ack[c]) ack_cnt[c]++;
         end
         if (bus_a.nsync == 2'b00) overlap++;
         if (!bus_a.nsync[cur_a.ch]) begin
            cur_a.low++;
            if (pb && !bus_a.bclk) begin
               cur_a.bits = {cur_a.bits[30:0], bus_a.sdata};
               cur_a.leads++;
            end
         end else if (!pn[cur_a.ch]) begin
            fa.push_back(cur_a);
         end
         pn = bus_a.nsync;
         pb = bus_a.bclk;
      end
   end

   // Frame recorder for the narrow build: CPOL=0, leading edges are rising.
   initial begin
      logic pn;
      logic pb;
      pn = 1'b1; pb = 1'b0;
      cur_b = '{0, 32'h0, 0, 0, 0};
      forever begin
         @(negedge clk);
         if (pn && !bus_b.nsync[0]) cur_b = '{0, 32'h0, 0, 0, cyc};
         if (!bus_b.nsync[0]) begin
            cur_b.low++;
            if (!pb && bus_b.bclk) begin
               cur_b.bits = {cur_b.bits[30:0], bus_b.sdata};
               cur_b.leads++;
            end
         end else if (!pn) begin
            fb.push_back(cur_b);
         end
         pn = bus_b.nsync[0];
         pb = bus_b.bclk;
      end
   end

   task automatic clear_mon();
      fa.delete();
      fb.delete();
      ack_cnt[0] = 0;
      ack_cnt[1] = 0;
   endtask

   task automatic do_reset();
      reset_n      = 1'b0;
      bus_a.dac_rq = '0;
      bus_b.dac_rq = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      clear_mon();
   endtask

   // Each requester keeps dac_rq high until it has seen the wanted number of acks.
   task automatic run_a(input int want0, input int want1, input int budget);
      int n;
      n = 0;
      while (n < budget) begin
         @(negedge clk);
         n++;
         if (ack_cnt[0] >= want0) bus_a.dac_rq[0] = 1'b0;
         if (ack_cnt[1] >= want1) bus_a.dac_rq[1] = 1'b0;
         if (bus_a.dac_rq == 2'b00 && !bus_a.busy && bus_a.nsync == 2'b11) break;
      end
      check("run_a_timeout", 64'(n < budget), 64'd1);
   endtask

   initial begin
      int n;
      n_vec = 0;
      n_err = 0;
      reset_n       = 1'b0;
      bus_a.dac_rq   = '0;
      bus_a.dac_data = '0;
      bus_b.dac_rq   = '0;
      bus_b.dac_data = '0;
      repeat (3) @(negedge clk);
      check("rst_nsync", 64'(bus_a.nsync), 64'h3);
      check("rst_bclk", 64'(bus_a.bclk), 64'h1);
      check("rst_sdata", 64'(bus_a.sdata), 64'h0);
      check("rst_ack", 64'(bus_a.dac_ack), 64'h0);
      check("rst_busy", 64'(bus_a.busy), 64'h0);
      check("rst_bclk_b", 64'(bus_b.bclk), 64'h0);
      reset_n = 1'b1;
      @(negedge clk);
      clear_mon();

      // Single frame on channel 0, with request-to-frame latency
      bus_a.dac_data = {16'h0000, 16'hA5C3};
      bus_a.dac_rq   = 2'b01;
      @(negedge clk);
      check("lat_e0_nsync", 64'(bus_a.nsync), 64'h3);
      @(negedge clk);
      check("lat_e1_nsync", 64'(bus_a.nsync), 64'h2);
      check("lat_e1_ack", 64'(bus_a.dac_ack), 64'h1);
      check("lat_e1_busy", 64'(bus_a.busy), 64'h1);
      run_a(1, 0, 400);
      f0 = fa_at(0);
      check("single_nframes", 64'(fa.size()), 64'd1);
      check("single_ch", 64'(f0.ch), 64'd0);
      check("single_bits", 64'(f0.bits), 64'h00A5C3);
      check("single_leads", 64'(f0.leads), 64'd24);
      check("single_low", 64'(f0.low), 64'd96);
      check("single_ack0", 64'(ack_cnt[0]), 64'd1);
      check("single_ack1", 64'(ack_cnt[1]), 64'd0);

      // Simultaneous requests right after reset
      do_reset();
      bus_a.dac_data = {16'h2222, 16'h1111};
      bus_a.dac_rq   = 2'b11;
      run_a(1, 1, 600);
      f0 = fa_at(0);
      f1 = fa_at(1);
      check("simul_nframes", 64'(fa.size()), 64'd2);
      check("simul_first_ch", 64'(f0.ch), 64'd0);
      check("simul_first_bits", 64'(f0.bits), 64'h001111);
      check("simul_second_ch", 64'(f1.ch), 64'd1);
      check("simul_second_bits", 64'(f1.bits), 64'h002222);
      check("simul_spacing", 64'(f1.start - f0.start), 64'd101);
      check("simul_ack0", 64'(ack_cnt[0]), 64'd1);
      check("simul_ack1", 64'(ack_cnt[1]), 64'd1);

      // Fairness with both channels held
      do_reset();
      bus_a.dac_data = {16'hBEEF, 16'h1234};
      bus_a.dac_rq   = 2'b11;
      run_a(2, 2, 1000);
      f0 = fa_at(0); f1 = fa_at(1); f2 = fa_at(2); f3 = fa_at(3);
      check("fair_nframes", 64'(fa.size()), 64'd4);
      check("fair_order", {32'(f0.ch), 32'(f1.ch)}, {32'd0, 32'd1});
      check("fair_order2", {32'(f2.ch), 32'(f3.ch)}, {32'd0, 32'd1});
      check("fair_bits1", 64'(f1.bits), 64'h00BEEF);
      check("fair_spacing", {16'(f1.start - f0.start), 16'(f2.start - f1.start), 16'(f3.start - f2.start)},
            {16'd101, 16'd101, 16'd101});

      // Late deassert produces a second frame of the same sample
      do_reset();
      bus_a.dac_data = {16'h0000, 16'h5A5A};
      bus_a.dac_rq   = 2'b01;
      run_a(2, 0, 600);
      f0 = fa_at(0);
      f1 = fa_at(1);
      check("late_nframes", 64'(fa.size()), 64'd2);
      check("late_bits", {f0.bits, f1.bits}, {32'h005A5A, 32'h005A5A});
      check("late_ch", {32'(f0.ch), 32'(f1.ch)}, 64'd0);
      check("late_spacing", 64'(f1.start - f0.start), 64'd101);
      check("late_ack0", 64'(ack_cnt[0]), 64'd2);

      // Narrow build: 16-bit frame, CPOL=0, 2 clocks per bclk
      bus_b.dac_data = 16'h8001;
      bus_b.dac_rq   = 1'b1;
      n = 0;
      while (n < 300) begin
         @(negedge clk);
         n++;
         if (bus_b.dac_ack[0]) bus_b.dac_rq = 1'b0;
         if (!bus_b.dac_rq[0] && !bus_b.busy && bus_b.nsync[0]) break;
      end
      check("narrow_timeout", 64'(n < 300), 64'd1);
      check("narrow_nframes", 64'(fb.size()), 64'd1);
      check("narrow_bits", (fb.size() > 0) ? 64'(fb[0].bits) : 64'hDEAD, 64'h8001);
      check("narrow_leads", (fb.size() > 0) ? 64'(fb[0].leads) : 64'd0, 64'd16);
      check("narrow_low", (fb.size() > 0) ? 64'(fb[0].low) : 64'd0, 64'd32);
      check("narrow_bclk_idle", 64'(bus_b.bclk), 64'h0);

      // Reset mid-frame, applied between clock edges
      clear_mon();
      bus_a.dac_data = {16'h0000, 16'hFFFF};
      bus_a.dac_rq   = 2'b01;
      n = 0;
      while (n < 300 && !(cur_a.leads >= 10 && !bus_a.nsync[0])) begin
         @(negedge clk);
         n++;
         if (bus_a.dac_ack[0]) bus_a.dac_rq = 2'b00;
      end
      check("mid_wait_timeout", 64'(n < 300), 64'd1);
      check("mid_sdata_pre", 64'(bus_a.sdata), 64'h1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_nsync", 64'(bus_a.nsync), 64'h3);
      check("mid_bclk", 64'(bus_a.bclk), 64'h1);
      check("mid_sdata", 64'(bus_a.sdata), 64'h0);
      check("mid_busy", 64'(bus_a.busy), 64'h0);
      bus_a.dac_rq = 2'b00;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check("post_nsync", 64'(bus_a.nsync), 64'h3);
      check("post_busy", 64'(bus_a.busy), 64'h0);
      check("post_bclk", 64'(bus_a.bclk), 64'h1);
      check("post_sdata", 64'(bus_a.sdata), 64'h0);
      check("post_ack_total", 64'(ack_cnt[0]), 64'd1);
      check("never_two_low", 64'(overlap), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/dac_spi_multi.md
# dac_spi_multi

Parametrised multi-channel SPI master for serial DACs of the AD5061 class, the successor of the single-channel DAC transmitter. Up to N_CHANNELS sample sources share one sdata/bclk pair, each with its own nsync line. Requests are arbitrated round-robin. Frame length, data width, command prefix, bit rate, clock polarity and inter-frame gap are set by parameters. It sits between the sample-producing datapath and the board-level DAC pins.

## Interface
- CLKS_PER_BCLK, 4: clock_in cycles per bclk period; even, >=2; H = CLKS_PER_BCLK/2.
- DATA_WIDTH, 16: sample bits per channel.
- FRAME_LENGTH, 24: bits per SPI frame; >= DATA_WIDTH.
- PREFIX, 0: (FRAME_LENGTH-DATA_WIDTH)-bit constant sent before the data, e.g. AD5061 power-down bits; unused when the widths are equal.
- N_CHANNELS, 2: number of DACs, 1..8.
- CPOL, 1: bclk idle level.
- MIN_GAP_CLKS, 4: minimum clock_in cycles with all nsync high between frames; >=1.
- clock_in  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- dac_data  input  N_CHANNELS*DATA_WIDTH  channel c sample in bits [c*DATA_WIDTH +: DATA_WIDTH]; held stable while dac_rq[c] is high.
- dac_rq  input  N_CHANNELS  level request per channel.
- dac_ack  output  N_CHANNELS  one-cycle pulse when that channel's sample is latched.
- busy  output  1  high from the latch cycle through the end of the gap.
- sdata  output  1  serial data, MSB first.
- bclk  output  1  serial clock.
- nsync  output  N_CHANNELS  active-low frame sync, one per DAC.

## Operation
- Reset (asserted low, acts immediately): nsync all 1, bclk = CPOL, sdata 0, dac_ack 0, busy 0, FSM IDLE, round-robin pointer so channel 0 has top priority.
- dac_rq passes through one register stage before arbitration.
- States:
  - IDLE: if any registered request is set, grant the first set channel at or after the pointer (wrapping). On the same edge:
    - latch frame {PREFIX, dac_data[c]};
    - pulse dac_ack[c];
    - drive nsync[c] low and sdata to the frame MSB;
    - set busy;
    - set the pointer to c+1 mod N_CHANNELS;
    - go to SETUP.
  - SETUP: H cycles, bclk at idle level; then go to SHIFT.
  - SHIFT: per bit, bclk leaves idle (leading edge, DAC samples) and holds H cycles, then returns to idle (trailing edge) and holds H cycles. On each trailing edge the frame register shifts left and sdata takes the next bit. On the FRAME_LENGTH-th trailing edge: nsync[c] returns high, sdata goes to 0, go to GAP.
  - GAP: MIN_GAP_CLKS cycles with all nsync high; busy falls on exit; go to IDLE.
- Only the granted channel's nsync is ever low; never two at once.
- A requester drops dac_rq in the cycle after it sees dac_ack. If dac_rq is still high when the FSM next reaches IDLE, it counts as a new request.
- Requests arriving during a frame wait. They are served in round-robin order after GAP; none is lost.
- Reset mid-frame aborts the frame: nsync rises before the last edge, so the DAC discards it. No dac_ack is regenerated.
- Invalid parameters (odd CLKS_PER_BCLK, FRAME_LENGTH < DATA_WIDTH) are not supported.

## Timing
- Cycle 0 is the first cycle with nsync[c] low; dac_ack[c] is high in cycle 0 only.
- A dac_rq rising edge sampled on clock edge E0 produces cycle 0 after edge E1 when IDLE. Latency is 2 edges.
- Bit i leading edge: cycle H + 2H*i.
- Bit i trailing edge: cycle 2H + 2H*i.
- nsync high from cycle 2H*FRAME_LENGTH. Low time is 2H*FRAME_LENGTH cycles (96 at defaults).
- Next earliest cycle 0: 2H*FRAME_LENGTH + MIN_GAP_CLKS + 1 cycles after the previous cycle 0 (one IDLE cycle). At defaults this is a frame period of 101 clocks.
- sdata is stable for H cycles before and H cycles after each leading edge.

## Test plan
- Single frame: defaults, channel 0 requests 0xA5C3 -> one ack pulse on ch0; nsync[0] low exactly 96 cycles; 24 leading edges; sdata reads 0x00A5C3 MSB first at the leading edges; nsync[1] stays high.
- Simultaneous requests after reset: ch0 = 0x1111, ch1 = 0x2222 -> ch0 framed first; ch1 nsync falls 101 cycles after ch0's; each ack exactly once.
- Fairness: ch0 and ch1 held high continuously for 4 frames -> service order 0,1,0,1, never two consecutive frames on one channel.
- Parameter sweep: CLKS_PER_BCLK=2, FRAME_LENGTH=16, PREFIX empty, CPOL=0, data 0x8001 -> bclk idles low; 16 rising leading edges; first and last sampled bits 1; nsync low 32 cycles.
- Reset mid-frame: reset low at bit 10 -> nsync, bclk, sdata, busy go to reset values without waiting for clock_in; after release with no request, FSM stays IDLE and outputs are unchanged.
- Late deassert: dac_rq held one frame past ack -> a second frame with the same data and a second ack pulse, separated by the minimum gap.
